// File: rtl/decoder_scan_reg.sv
// Registered IN_W-to-2**IN_W decoder with one-hot, thermometer, free-running scan
// and bounded scan output modes. Scan modes step an internal index every SCAN_DIV clocks.
module decoder_scan_reg #(
    parameter int unsigned IN_W     = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [IN_W-1:0]      binary_in,
    output logic [(2**IN_W)-1:0] decoder_out,
    output logic                 out_valid,
    output logic [IN_W-1:0]      scan_idx,
    output logic                 wrap
);

    localparam int unsigned OUT_W = 2 ** IN_W;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IN_W-1:0]  IDX_MAX  = IN_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IN_W-1:0]  idx_d;
    logic [OUT_W-1:0] out_d;
    logic             valid_d;
    logic             wrap_d;

    logic             mode_chg;
    logic             step;
    logic [IN_W-1:0]  limit;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] thermo;

    // Static decode of binary_in in both forms
    always_comb begin
        onehot = OUT_W'(1) << binary_in;
        thermo = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            thermo[i] = (i <= 32'(binary_in));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = scan_idx;
        out_d    = '0;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        mode_chg = (mode != mode_q);
        step     = (div_q == DIV_LAST);
        limit    = mode[0] ? binary_in : IDX_MAX;

        if (!enable) begin
            state_d = IDLE;
            div_d   = '0;
            idx_d   = '0;
        end else if (!mode[1]) begin
            state_d = STATIC;
            div_d   = '0;
            idx_d   = '0;
            out_d   = mode[0] ? thermo : onehot;
            valid_d = (state_q != IDLE) && !mode_chg;
        end else begin
            state_d = SCAN;
            valid_d = (state_q != IDLE) && !mode_chg;
            if ((state_q != SCAN) || mode_chg) begin
                // Fresh scan always starts at index 0
                div_d = '0;
                idx_d = '0;
            end else if (step) begin
                div_d = '0;
                // An index above a lowered limit also returns to 0
                if (scan_idx >= limit) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = scan_idx + IN_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            out_d = OUT_W'(1) << idx_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            div_q       <= '0;
            scan_idx    <= '0;
            decoder_out <= '0;
            out_valid   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode;
            div_q       <= div_d;
            scan_idx    <= idx_d;
            decoder_out <= out_d;
            out_valid   <= valid_d;
            wrap        <= wrap_d;
        end
    end

endmodule
